// File: rtl/pap_update_queue_if.sv
// pap_update_queue_if: groups the resolution-side and predictor-side signals of the PAp
// update queue into one bundle.
//
// Signals:
//   in_valid/in_index/in_hist/in_taken/in_mispred/in_condbr  per-lane resolved branch results
//   in_ready                                                queue accepts a full IN_WIDTH burst
//   out_valid/out_index/out_hist/out_taken/out_mispred/out_condbr  per-port predictor updates
//   out_ready                                               predictor takes all valid ports
//   count                                                   current occupancy
//   drop_cnt                                                saturating count of dropped lanes
//
// Modports:
//   master  the environment side (resolution lanes plus predictor update ports)
//   slave   the queue itself
interface pap_update_queue_if #(
    parameter int unsigned IN_WIDTH   = 2,
    parameter int unsigned OUT_WIDTH  = 2,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned HIST_BITS  = 8
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [IN_WIDTH-1:0]             in_valid;
    logic [IN_WIDTH*INDEX_BITS-1:0]  in_index;
    logic [IN_WIDTH*HIST_BITS-1:0]   in_hist;
    logic [IN_WIDTH-1:0]             in_taken;
    logic [IN_WIDTH-1:0]             in_mispred;
    logic [IN_WIDTH-1:0]             in_condbr;
    logic                            in_ready;

    logic [OUT_WIDTH-1:0]            out_valid;
    logic [OUT_WIDTH*INDEX_BITS-1:0] out_index;
    logic [OUT_WIDTH*HIST_BITS-1:0]  out_hist;
    logic [OUT_WIDTH-1:0]            out_taken;
    logic [OUT_WIDTH-1:0]            out_mispred;
    logic [OUT_WIDTH-1:0]            out_condbr;
    logic                            out_ready;

    logic [CntW-1:0]                 count;
    logic [7:0]                      drop_cnt;

    modport master (
        output in_valid, in_index, in_hist, in_taken, in_mispred, in_condbr, out_ready,
        input  in_ready, out_valid, out_index, out_hist, out_taken, out_mispred, out_condbr,
        input  count, drop_cnt
    );

    modport slave (
        input  in_valid, in_index, in_hist, in_taken, in_mispred, in_condbr, out_ready,
        output in_ready, out_valid, out_index, out_hist, out_taken, out_mispred, out_condbr,
        output count, drop_cnt
    );
endinterface

// File: rtl/pap_update_queue.sv
// pap_update_queue: circular buffer between the integer branch-resolution lanes and the
// PAp predictor's PHT-counter / history-recovery write ports.
//
// Resolved results arrive up to IN_WIDTH per cycle, are compacted in ascending lane order and
// queued in strict FIFO order. Up to two entries are presented show-ahead to the predictor;
// the second port is suppressed whenever it would write the same PHT index as the first.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   flush  (only with PAP_UPDATE_QUEUE_FLUSH_EN) discard all queued and same-cycle entries
//   bus    pap_update_queue_if.slave: lane inputs, update outputs, count, drop_cnt
//
// Optional feature macro: PAP_UPDATE_QUEUE_FLUSH_EN (adds the flush input after rst).
// The update-port logic is written for OUT_WIDTH == 2.
module pap_update_queue #(
    parameter int unsigned IN_WIDTH   = 2,
    parameter int unsigned OUT_WIDTH  = 2,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned HIST_BITS  = 8
) (
    input logic               clk,
    input logic               rst,
`ifdef PAP_UPDATE_QUEUE_FLUSH_EN
    input logic               flush,
`endif
    pap_update_queue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Entry storage, one array per payload field.
    logic [INDEX_BITS-1:0] idx_q  [DEPTH];
    logic [HIST_BITS-1:0]  hist_q [DEPTH];
    logic [DEPTH-1:0]      taken_q;
    logic [DEPTH-1:0]      mispred_q;
    logic [DEPTH-1:0]      condbr_q;

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      drop_q, drop_d;

    logic                 flush_w;
    logic [CntW:0]        free_w;
    logic                 in_ready_w;
    logic [OUT_WIDTH-1:0] out_valid_w;
    logic [PtrW-1:0]      head1_w;
    logic [PtrW-1:0]      lane_off [IN_WIDTH];
    logic [CntW-1:0]      in_pop;
    logic [CntW-1:0]      enq_n;
    logic [CntW-1:0]      deq_n;
    logic                 enq_en;
    logic                 drop_en;
    logic [8:0]           drop_sum;

`ifdef PAP_UPDATE_QUEUE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Acceptance depends only on registered occupancy, so a same-cycle pop never helps.
    assign free_w     = (CntW + 1)'(DEPTH) - {1'b0, count_q};
    assign in_ready_w = !rst && (free_w >= (CntW + 1)'(IN_WIDTH));
    assign head1_w    = head_q + PtrW'(1);

    // Port 1 is offered only when it cannot collide with port 0 on the same PHT index,
    // and only together with port 0.
    always_comb begin
        out_valid_w = '0;
        if (!rst && !flush_w) begin
            out_valid_w[0] = (count_q != '0);
            out_valid_w[1] = (count_q >= CntW'(2)) && (idx_q[head1_w] != idx_q[head_q]);
        end
    end

    // Show-ahead payload straight from storage; slots beyond the occupancy read as zero.
    always_comb begin
        bus.out_index   = '0;
        bus.out_hist    = '0;
        bus.out_taken   = '0;
        bus.out_mispred = '0;
        bus.out_condbr  = '0;
        for (int p = 0; p < OUT_WIDTH; p++) begin
            if (count_q > CntW'(p)) begin
                bus.out_index[p*INDEX_BITS +: INDEX_BITS] = idx_q[head_q + PtrW'(p)];
                bus.out_hist[p*HIST_BITS +: HIST_BITS]    = hist_q[head_q + PtrW'(p)];
                bus.out_taken[p]                          = taken_q[head_q + PtrW'(p)];
                bus.out_mispred[p]                        = mispred_q[head_q + PtrW'(p)];
                bus.out_condbr[p]                         = condbr_q[head_q + PtrW'(p)];
            end
        end
    end

    // Lane compaction: each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        in_pop = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            lane_off[i] = in_pop[PtrW-1:0];
            in_pop      = in_pop + CntW'(bus.in_valid[i]);
        end
    end

    assign enq_en  = in_ready_w && !flush_w;
    assign enq_n   = enq_en ? in_pop : '0;
    assign drop_en = !rst && !flush_w && !in_ready_w && (in_pop != '0);
    assign deq_n   = bus.out_ready ? (CntW'(out_valid_w[0]) + CntW'(out_valid_w[1])) : '0;

    assign drop_sum = {1'b0, drop_q} + 9'(in_pop);

    always_comb begin
        drop_d = drop_q;
        if (drop_en) begin
            drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign count_d = count_q + enq_n - deq_n;
    assign tail_d  = tail_q + enq_n[PtrW-1:0];
    assign head_d  = head_q + deq_n[PtrW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else if (flush_w) begin
            head_q  <= tail_q;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Storage is cleared on reset so that nothing undefined can ever reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                idx_q[e]  <= '0;
                hist_q[e] <= '0;
            end
            taken_q   <= '0;
            mispred_q <= '0;
            condbr_q  <= '0;
        end else if (enq_en) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (bus.in_valid[i]) begin
                    idx_q[tail_q + lane_off[i]]     <= bus.in_index[i*INDEX_BITS +: INDEX_BITS];
                    hist_q[tail_q + lane_off[i]]    <= bus.in_hist[i*HIST_BITS +: HIST_BITS];
                    taken_q[tail_q + lane_off[i]]   <= bus.in_taken[i];
                    mispred_q[tail_q + lane_off[i]] <= bus.in_mispred[i];
                    condbr_q[tail_q + lane_off[i]]  <= bus.in_condbr[i];
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.count     = count_q;
    assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_pap_update_queue.sv
// Testbench for pap_update_queue: directed vector table, wrap/reset/flush sequences and a
// randomized run against a queue-based reference model.
module tb_pap_update_queue;
    localparam int unsigned IW    = 2;
    localparam int unsigned OW    = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned IB    = 8;
    localparam int unsigned HB    = 8;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    pap_update_queue_if #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .INDEX_BITS(IB), .HIST_BITS(HB)
    ) bus ();

    pap_update_queue #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .INDEX_BITS(IB), .HIST_BITS(HB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef PAP_UPDATE_QUEUE_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [IB-1:0] idx;
        logic [HB-1:0] hist;
        logic          tk;
        logic          mp;
        logic          cb;
    } ent_t;

    ent_t mq[$];
    int   mdrop = 0;

    typedef struct {
        logic [1:0] v;
        logic [7:0] i0;
        logic [7:0] i1;
        logic       ordy;
        logic [1:0] eov;
        logic [7:0] ei0;
        logic [7:0] ei1;
        int         ecnt;
        logic       erdy;
        int         edrop;
    } vec_t;

    vec_t tbl [18];
    logic [7:0] got[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] i0, input logic [7:0] i1,
                         input logic ordy);
        bus.in_valid   = v;
        bus.in_index   = {i1, i0};
        bus.in_hist    = 16'($urandom);
        bus.in_taken   = 2'($urandom);
        bus.in_mispred = 2'($urandom);
        bus.in_condbr  = 2'($urandom);
        bus.out_ready  = ordy;
    endtask

    // Reference: which of the two oldest entries may be presented this cycle.
    function automatic logic [1:0] model_ov();
        logic [1:0] ov;
        ov = 2'b00;
        if (rst || flush) return ov;
        if (mq.size() >= 1) ov[0] = 1'b1;
        if (mq.size() >= 2 && mq[1].idx != mq[0].idx) ov[1] = 1'b1;
        return ov;
    endfunction

    task automatic model_update();
        logic [1:0] ov;
        int         npop;
        int         nin;
        bit         rdy;
        ent_t       e;
        if (rst) begin
            mq.delete();
            mdrop = 0;
            return;
        end
        if (flush) begin
            mq.delete();
            return;
        end
        ov   = model_ov();
        rdy  = (int'(DEPTH) - mq.size()) >= int'(IW);
        npop = bus.out_ready ? (int'(ov[0]) + int'(ov[1])) : 0;
        repeat (npop) void'(mq.pop_front());
        nin = 0;
        for (int i = 0; i < int'(IW); i++) begin
            if (bus.in_valid[i]) begin
                nin++;
                e.idx  = bus.in_index[i*IB +: IB];
                e.hist = bus.in_hist[i*HB +: HB];
                e.tk   = bus.in_taken[i];
                e.mp   = bus.in_mispred[i];
                e.cb   = bus.in_condbr[i];
                if (rdy) mq.push_back(e);
            end
        end
        if (!rdy && nin > 0) mdrop = (mdrop + nin > 255) ? 255 : mdrop + nin;
    endtask

    task automatic model_check(input string tag);
        logic [1:0] eov;
        logic       erdy;
        eov  = model_ov();
        erdy = !rst && ((int'(DEPTH) - mq.size()) >= int'(IW));
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(erdy));
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(eov));
        chk({tag, ".count"}, 64'(bus.count), 64'(mq.size()));
        chk({tag, ".drop_cnt"}, 64'(bus.drop_cnt), 64'(mdrop));
        for (int p = 0; p < 2; p++) begin
            if (eov[p]) begin
                chk($sformatf("%s.payload%0d", tag, p),
                    64'({bus.out_index[p*IB +: IB], bus.out_hist[p*HB +: HB],
                         bus.out_taken[p], bus.out_mispred[p], bus.out_condbr[p]}),
                    64'({mq[p].idx, mq[p].hist, mq[p].tk, mq[p].mp, mq[p].cb}));
            end
        end
        if (mq.size() == 0) begin
            chk({tag, ".empty_payload"},
                64'({bus.out_index, bus.out_hist, bus.out_taken, bus.out_mispred,
                     bus.out_condbr}), 64'(0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic collect();
        if (bus.out_valid[0]) got.push_back(bus.out_index[7:0]);
        if (bus.out_valid[1]) got.push_back(bus.out_index[15:8]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] v;
        bit         drained;

        // {in_valid, idx0, idx1, out_ready, exp out_valid, exp idx0, exp idx1, exp count,
        //  exp in_ready, exp drop_cnt}; expectations are for the cycle the inputs are applied.
        tbl[0]  = '{2'b11, 8'h12, 8'h34, 1'b1, 2'b00, 8'h00, 8'h00, 0, 1'b1, 0};
        tbl[1]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 8'h12, 8'h34, 2, 1'b1, 0};
        tbl[2]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 8'h00, 8'h00, 0, 1'b1, 0};
        tbl[3]  = '{2'b11, 8'h20, 8'h20, 1'b1, 2'b00, 8'h00, 8'h00, 0, 1'b1, 0};
        tbl[4]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 8'h20, 8'h00, 2, 1'b1, 0};
        tbl[5]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 8'h20, 8'h00, 1, 1'b1, 0};
        tbl[6]  = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00, 0, 1'b1, 0};
        tbl[7]  = '{2'b11, 8'h01, 8'h02, 1'b0, 2'b00, 8'h00, 8'h00, 0, 1'b1, 0};
        tbl[8]  = '{2'b11, 8'h03, 8'h04, 1'b0, 2'b11, 8'h01, 8'h02, 2, 1'b1, 0};
        tbl[9]  = '{2'b11, 8'h05, 8'h06, 1'b0, 2'b11, 8'h01, 8'h02, 4, 1'b1, 0};
        tbl[10] = '{2'b11, 8'h07, 8'h08, 1'b0, 2'b11, 8'h01, 8'h02, 6, 1'b1, 0};
        tbl[11] = '{2'b11, 8'h09, 8'h0a, 1'b0, 2'b11, 8'h01, 8'h02, 8, 1'b0, 0};
        tbl[12] = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 8'h01, 8'h02, 8, 1'b0, 2};
        tbl[13] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 8'h01, 8'h02, 8, 1'b0, 2};
        tbl[14] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 8'h03, 8'h04, 6, 1'b1, 2};
        tbl[15] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 8'h05, 8'h06, 4, 1'b1, 2};
        tbl[16] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 8'h07, 8'h08, 2, 1'b1, 2};
        tbl[17] = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00, 0, 1'b1, 2};

        // Reset with lanes active: they must be ignored.
        rst   = 1'b1;
        flush = 1'b0;
        drive(2'b11, 8'h55, 8'h66, 1'b1);
        @(negedge clk);
        #1;
        chk("reset.in_ready", 64'(bus.in_ready), 64'(0));
        chk("reset.out_valid", 64'(bus.out_valid), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        #1;
        chk("post_reset.count", 64'(bus.count), 64'(0));
        chk("post_reset.drop_cnt", 64'(bus.drop_cnt), 64'(0));
        chk("post_reset.in_ready", 64'(bus.in_ready), 64'(1));
        chk("post_reset.out_valid", 64'(bus.out_valid), 64'(0));

        // Directed table: pair enqueue, same-index conflict, fill / overflow / drain.
        for (int k = 0; k < 18; k++) begin
            drive(tbl[k].v, tbl[k].i0, tbl[k].i1, tbl[k].ordy);
            #1;
            chk($sformatf("vec%0d.out_valid", k), 64'(bus.out_valid), 64'(tbl[k].eov));
            chk($sformatf("vec%0d.count", k), 64'(bus.count), 64'(tbl[k].ecnt));
            chk($sformatf("vec%0d.in_ready", k), 64'(bus.in_ready), 64'(tbl[k].erdy));
            chk($sformatf("vec%0d.drop_cnt", k), 64'(bus.drop_cnt), 64'(tbl[k].edrop));
            if (tbl[k].eov[0] || tbl[k].ecnt == 0)
                chk($sformatf("vec%0d.idx0", k), 64'(bus.out_index[7:0]), 64'(tbl[k].ei0));
            if (tbl[k].eov[1] || tbl[k].ecnt == 0)
                chk($sformatf("vec%0d.idx1", k), 64'(bus.out_index[15:8]), 64'(tbl[k].ei1));
            tick();
        end

        // Wrap-around ordering: single-lane enqueues on alternating lanes, sparse pops.
        got.delete();
        for (int k = 0; k < 10; k++) begin
            v = (k % 2 == 1) ? 2'b10 : 2'b01;
            drive(v, 8'(k), 8'(k), (k % 3 == 2));
            #1;
            if (bus.out_ready) collect();
            tick();
        end
        drained = 1'b0;
        for (int c = 0; c < 20 && !drained; c++) begin
            drive(2'b00, 8'h00, 8'h00, 1'b1);
            #1;
            if (bus.count == 0) drained = 1'b1;
            else collect();
            tick();
        end
        chk("wrap.drained", 64'(drained), 64'(1));
        chk("wrap.len", 64'(got.size()), 64'(10));
        for (int k = 0; k < 10; k++) begin
            if (k < got.size()) chk($sformatf("wrap.order%0d", k), 64'(got[k]), 64'(k));
        end

        // Reset mid-stream with five entries queued and a drop recorded earlier.
        drive(2'b11, 8'h01, 8'h02, 1'b0);
        tick();
        drive(2'b11, 8'h03, 8'h04, 1'b0);
        tick();
        drive(2'b01, 8'h05, 8'h00, 1'b0);
        tick();
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        #1;
        chk("midrst.count_before", 64'(bus.count), 64'(5));
        chk("midrst.drop_before", 64'(bus.drop_cnt), 64'(2));
        rst = 1'b1;
        drive(2'b11, 8'h07, 8'h08, 1'b1);
        #1;
        chk("midrst.in_ready_in_reset", 64'(bus.in_ready), 64'(0));
        chk("midrst.out_valid_in_reset", 64'(bus.out_valid), 64'(0));
        tick();
        rst = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        #1;
        chk("midrst.count", 64'(bus.count), 64'(0));
        chk("midrst.out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst.drop_cnt", 64'(bus.drop_cnt), 64'(0));
        tick();
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        #1;
        chk("midrst.in_ready_after", 64'(bus.in_ready), 64'(1));
        tick();

        // Randomized traffic with a small index range so same-index conflicts are common.
        for (int c = 0; c < 500; c++) begin
            drive(2'($urandom), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < ((c < 250) ? 40 : 80)));
            #1;
            model_check("rand");
            tick();
        end

        // Hold the predictor off until the drop counter saturates.
        for (int c = 0; c < 140; c++) begin
            drive(2'b11, 8'($urandom), 8'($urandom), 1'b0);
            #1;
            model_check("sat");
            tick();
        end
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        #1;
        chk("sat.drop_cnt", 64'(bus.drop_cnt), 64'(255));
        chk("sat.count", 64'(bus.count), 64'(8));

        drained = 1'b0;
        for (int c = 0; c < 20 && !drained; c++) begin
            drive(2'b00, 8'h00, 8'h00, 1'b1);
            #1;
            model_check("drain");
            if (mq.size() == 0) drained = 1'b1;
            tick();
        end
        chk("drain.done", 64'(drained), 64'(1));

`ifdef PAP_UPDATE_QUEUE_FLUSH_EN
        drive(2'b11, 8'h01, 8'h02, 1'b0);
        tick();
        drive(2'b01, 8'h03, 8'h00, 1'b0);
        tick();
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        #1;
        chk("flush.count_before", 64'(bus.count), 64'(3));
        flush = 1'b1;
        drive(2'b11, 8'h05, 8'h06, 1'b1);
        #1;
        chk("flush.out_valid_in_flush", 64'(bus.out_valid), 64'(0));
        model_check("flush_cycle");
        tick();
        flush = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        #1;
        chk("flush.count", 64'(bus.count), 64'(0));
        chk("flush.out_valid", 64'(bus.out_valid), 64'(0));
        chk("flush.drop_cnt", 64'(bus.drop_cnt), 64'(255));
        tick();
        drive(2'b01, 8'h09, 8'h00, 1'b0);
        tick();
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        #1;
        model_check("after_flush");
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
